// File: rtl/if_bus_if_pkg.sv
// Shared definitions for the instruction-fetch Wishbone bridge: FSM state
// encodings, reset polarity and bus constants.
package if_bus_if_pkg;

  typedef enum logic [1:0] {
    IF_BUS_IDLE       = 2'b00,
    IF_BUS_BUSY       = 2'b01,
    IF_BUS_WAIT_STALL = 2'b10
  } if_bus_state_t;

  localparam logic [31:0] ZeroWord    = 32'h0000_0000;
  localparam logic        RstEnable   = 1'b1;
  localparam logic [3:0]  WB_SEL_WORD = 4'b1111;

endpackage

// File: rtl/if_bus_if.sv
// Instruction-fetch bridge: one Wishbone classic read per fetch, stall request
// until the word arrives, flush abort and hold of the word during pipeline stall.
// Optional ack watchdog enabled by defining IF_BUS_TIMEOUT_EN.
module if_bus_if
  import if_bus_if_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              ce,
  input  logic [5:0]        stall,
  input  logic              flush,
  output logic [DATA_W-1:0] inst_o,
  output logic              stallreq_o,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [3:0]        wb_sel_o,
  output logic [ADDR_W-1:0] wb_adr_o,
  input  logic [DATA_W-1:0] wb_dat_i,
  input  logic              wb_ack_i
`ifdef IF_BUS_TIMEOUT_EN
  ,
  output logic              bus_err_o
`endif
);

  localparam logic [ADDR_W-1:0] ADR_MASK = ~ADDR_W'(3);

  if_bus_state_t     state;
  logic [DATA_W-1:0] rd_buf;
  logic              timeout_hit;

`ifdef IF_BUS_TIMEOUT_EN
  localparam int TO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [TO_W-1:0] to_cnt;

  // The cycle in which the count shows TIMEOUT_CYCLES-1 is the last BUSY cycle allowed.
  assign timeout_hit = (state == IF_BUS_BUSY) && !wb_ack_i &&
                       (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  assign wb_we_o = 1'b0;

  always_comb begin
    inst_o     = '0;
    stallreq_o = 1'b0;
    if (rst != RstEnable) begin
      case (state)
        IF_BUS_IDLE: stallreq_o = ce & ~flush;
        IF_BUS_BUSY: begin
          if (!flush) begin
            if (wb_ack_i)          inst_o     = wb_dat_i;
            else if (!timeout_hit) stallreq_o = 1'b1;
          end
        end
        IF_BUS_WAIT_STALL: inst_o = rd_buf;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state    <= IF_BUS_IDLE;
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      wb_sel_o <= 4'b0000;
      wb_adr_o <= '0;
      rd_buf   <= '0;
`ifdef IF_BUS_TIMEOUT_EN
      to_cnt    <= '0;
      bus_err_o <= 1'b0;
`endif
    end else begin
`ifdef IF_BUS_TIMEOUT_EN
      bus_err_o <= 1'b0;
`endif
      case (state)
        IF_BUS_IDLE: begin
          if (ce && !flush) begin
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_sel_o <= WB_SEL_WORD;
            wb_adr_o <= pc & ADR_MASK;
            state    <= IF_BUS_BUSY;
`ifdef IF_BUS_TIMEOUT_EN
            to_cnt   <= '0;
`endif
          end
        end
        IF_BUS_BUSY: begin
          if (flush || wb_ack_i || timeout_hit) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_sel_o <= 4'b0000;
          end
          // Flush outranks a coincident ack: the returned word is simply dropped.
          if (flush) begin
            state <= IF_BUS_IDLE;
`ifdef IF_BUS_TIMEOUT_EN
            to_cnt <= '0;
`endif
          end else if (wb_ack_i) begin
            rd_buf <= wb_dat_i;
            state  <= (stall != 6'b0) ? IF_BUS_WAIT_STALL : IF_BUS_IDLE;
          end else if (timeout_hit) begin
            state <= IF_BUS_IDLE;
`ifdef IF_BUS_TIMEOUT_EN
            to_cnt    <= '0;
            bus_err_o <= 1'b1;
`endif
          end else begin
`ifdef IF_BUS_TIMEOUT_EN
            to_cnt <= to_cnt + 1'b1;
`endif
          end
        end
        IF_BUS_WAIT_STALL: begin
          if (stall == 6'b0 || flush) state <= IF_BUS_IDLE;
        end
        default: state <= IF_BUS_IDLE;
      endcase
    end
  end

endmodule
